// File: rtl/debounce_sync_if.sv
// debounce_sync_if: level-in / debounced-level-out bundle for debounce_sync.
//   din   : raw asynchronous level (driven by master)
//   q     : debounced, synchronized level
//   q_bar : ~q
//   rise  : one-cycle pulse on an accepted 0->1 change of q
//   fall  : one-cycle pulse on an accepted 1->0 change of q
interface debounce_sync_if;
  logic din;
  logic q;
  logic q_bar;
  logic rise;
  logic fall;

  modport master (output din, input q, q_bar, rise, fall);
  modport slave  (input din, output q, q_bar, rise, fall);
endinterface

// File: rtl/debounce_sync.sv
// debounce_sync: synchronizes an asynchronous level and accepts a change only
// after DEBOUNCE_CYCLES consecutive synchronized cycles that disagree with q.
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : debounce_sync_if.slave (din in; q, q_bar, rise, fall out)
// Latency for a stable din level: SYNC_STAGES + DEBOUNCE_CYCLES edges.

// Single resettable register stage used to build the synchronizer chain.
module debounce_sync_dff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) o_q <= RST_VAL;
    else          o_q <= i_d;
endmodule

module debounce_sync #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  debounce_sync_if.slave    bus
);
  // Width holds DEBOUNCE_CYCLES-1; at least one bit so DEBOUNCE_CYCLES=1 builds.
  localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // w_sync[0] is raw din, w_sync[SYNC_STAGES] is the only tap used downstream.
  logic [SYNC_STAGES:0] w_sync;
  logic                 w_sync_out;

  assign w_sync[0]  = bus.din;
  assign w_sync_out = w_sync[SYNC_STAGES];

  for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
    debounce_sync_dff #(.RST_VAL(RESET_VALUE)) u_ff (
      .clk     (clk),
      .reset_n (reset_n),
      .i_d     (w_sync[g]),
      .o_q     (w_sync[g+1])
    );
  end

  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_q, w_q_nxt;
  logic          r_rise, w_rise_nxt;
  logic          r_fall, w_fall_nxt;

  // Any cycle where sync_out agrees with q clears the count, so a short
  // excursion never accumulates across gaps. Counter stops at CNT_LAST and
  // the accepting edge reloads 0, so it never wraps.
  always_comb begin
    w_cnt_nxt  = '0;
    w_q_nxt    = r_q;
    w_rise_nxt = 1'b0;
    w_fall_nxt = 1'b0;
    if (w_sync_out != r_q) begin
      if (r_cnt == CNT_LAST) begin
        w_q_nxt    = w_sync_out;
        w_rise_nxt = w_sync_out;
        w_fall_nxt = ~w_sync_out;
      end else begin
        w_cnt_nxt  = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_q    <= RESET_VALUE;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_q    <= w_q_nxt;
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
    end
  end

  assign bus.q     = r_q;
  assign bus.q_bar = ~r_q;
  assign bus.rise  = r_rise;
  assign bus.fall  = r_fall;
endmodule
